mem_dump_sequencer: RTL and testbench
=====================================

Name: mem_dump_sequencer

Overview:
- Automatic memory-dump walker between the dump_mem button path and the 256x16 RAM / display controller; replaces the manual single-step dump counter.
- On start, walks RAM addresses 0..LAST_ADDR, drives the address into the RAM address mux, and captures each returned word.
- Holds each {address, data} pair for DWELL_CYCLES, or until a manual step in manual mode, as the 32-bit display word.
- Also exposes dump_active to steer the address mux away from the processor.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 16, RAM data width
LAST_ADDR, 255, final address walked (inclusive)
DWELL_CYCLES, 50000000, clk cycles each word is displayed in auto mode (min 1)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse (debounced); begins dump from address 0
step  input  1  single-cycle pulse (debounced); advances one word in manual mode
auto_mode  input  1  1 = advance on dwell timer, 0 = advance on step
mem_d_in  input  DATA_W  RAM read data, valid 1 cycle after addr_out changes
addr_out  output  ADDR_W  RAM read address
dump_active  output  1  high while not IDLE; selects addr_out at RAM address mux
disp_word  output  32  {zero-extended addr_out to 16b, captured word}
done  output  1  high in DONE state

Behaviour:
- Reset (reset low, async): state IDLE, addr_out 0, dump_active 0, disp_word 0, done 0, dwell counter 0, captured word 0.
- States: IDLE, ISSUE, CAPTURE, DWELL, DONE.
- IDLE: start -> ISSUE with addr_out = 0. step ignored.
- ISSUE: one cycle covering RAM read latency; -> CAPTURE.
- CAPTURE: register mem_d_in into the captured word, clear dwell counter; -> DWELL.
- DWELL, auto_mode=1: counter increments each cycle. At count == DWELL_CYCLES-1, advance.
- DWELL, auto_mode=0: counter held at 0; advance on step.
- Advance when addr_out != LAST_ADDR: addr_out+1, -> ISSUE.
- Advance when addr_out == LAST_ADDR: -> DONE with addr_out and word frozen. No wrap.
- DONE: done=1, display frozen. Next start -> ISSUE at address 0; step ignored.
- start in ISSUE/CAPTURE/DWELL: restart, addr_out=0 -> ISSUE. start has priority over step and timer in the same cycle.
- auto_mode toggled mid-DWELL: takes effect next cycle; counter continues from its current value when switching to auto.
- Latency: start to first valid disp_word = 3 cycles (ISSUE, CAPTURE, registered output).
- dump_active is 1 in every state except IDLE.
- disp_word updates only in CAPTURE (low half) and with addr_out (high half). Display never shows an address paired with the previous address's data.
- Counter width: $clog2(DWELL_CYCLES)+1. No overflow possible.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN
- With macro defined:
  - 16-bit modular sum of all captured words, cleared on start and on reset.
  - In DONE, disp_word = {16'hC5C5, checksum}.
  - Extra output checksum [15:0], reset 0.
- Without macro: no checksum logic or port; DONE displays the last {address, word}.

Decomposition:
- Package mem_dump_pkg:
  - state enum (IDLE=0, ISSUE=1, CAPTURE=2, DWELL=3, DONE=4)
  - checksum tag constant 16'hC5C5
  - default ADDR_W/DATA_W
- One sub-module: dump_dwell_timer (load/clear, enable, terminal-count pulse), reusable by the display controller's refresh logic.

Test Plan:
- Reset mid-DWELL at addr 5 -> all outputs 0 and state IDLE, asynchronously, before the next clk edge.
- RAM preloaded mem[i]=16'hA000+i, DWELL_CYCLES=4, LAST_ADDR=3, auto_mode=1, start -> disp_word sequence 0000A000, 0001A001, 0002A002, 0003A003, each held 4 cycles; then done=1, frozen on 0003A003.
- Manual mode, LAST_ADDR=3: start, 3 step pulses -> addr_out 0,1,2,3 after each step+2 cycles; a 4th step -> DONE; a 5th step -> no change.
- start asserted during DWELL at addr 2 -> addr_out=0 next cycle, disp_word high half 0000, dump_active stays 1.
- start and step in the same DWELL cycle -> restart to addr 0, no increment.
- MEM_DUMP_CHECKSUM_EN, words 1,2,3,FFFF, LAST_ADDR=3 -> DONE disp_word = C5C50005, checksum = 0005.

Source files
------------

// File: rtl/mem_dump_sequencer_pkg.sv
// mem_dump_pkg: shared constants for the memory-dump walker.
//   - FSM state encodings (legacy-compatible localparams, 3 bits)
//   - checksum display tag shown in DONE when MEM_DUMP_CHECKSUM_EN is defined
//   - default RAM address/data widths
package mem_dump_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [15:0] CHECKSUM_TAG = 16'hC5C5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_DWELL   = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/mem_dump_sequencer_dwell_timer.sv
// dump_dwell_timer: up-counter with synchronous clear, count enable and a
// terminal-count pulse. tc is high for the enabled cycle in which the count
// equals CYCLES-1; the counter wraps to 0 on that cycle so it can also serve
// as a free-running refresh divider.
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset (count -> 0)
//   clear  in   synchronous clear, wins over en
//   en     in   count enable
//   tc     out  terminal count (combinational, qualified by en)
module dump_dwell_timer #(
  parameter int CYCLES = 50000000,
  parameter int CW     = $clog2(CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] TERM = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  assign tc = en && (count == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (en)     count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/mem_dump_sequencer.sv
// mem_dump_sequencer: automatic RAM dump walker. On start it walks addresses
// 0..LAST_ADDR, captures each word one cycle after the address is issued and
// holds {addr, word} on the display for DWELL_CYCLES (auto_mode=1) or until
// a step pulse (auto_mode=0). Stops in DONE with the last pair frozen.
// Optional build macro: MEM_DUMP_CHECKSUM_EN -- adds a 16-bit running sum of
// captured words (checksum port) and shows {C5C5, checksum} in DONE.
// Ports:
//   clk          in   clock
//   reset        in   async active-low reset
//   start        in   pulse, (re)starts the dump at address 0 from any state
//   step         in   pulse, advances one word in manual mode
//   auto_mode    in   1 = dwell timer advances, 0 = step advances
//   mem_d_in     in   RAM read data, valid one cycle after addr_out changes
//   addr_out     out  RAM read address
//   dump_active  out  high in every state but IDLE (RAM address mux select)
//   disp_word    out  {zero-extended addr_out, captured word}
//   done         out  high in DONE
//   checksum     out  (MEM_DUMP_CHECKSUM_EN only) sum of captured words
module mem_dump_sequencer
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LAST_ADDR    = 255,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              auto_mode,
  input  logic [DATA_W-1:0] mem_d_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              dump_active,
  output logic [31:0]       disp_word,
  output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state;
  logic [DATA_W-1:0] cap_word;
  logic              in_dwell, adv, tc, tmr_clr, tmr_en;

  assign in_dwell = (state == ST_DWELL);
  assign tmr_en   = in_dwell && auto_mode;
  // Manual mode pins the counter at 0; switching to auto resumes from there.
  assign tmr_clr  = start || (state == ST_CAPTURE) || (in_dwell && !auto_mode);
  assign adv      = in_dwell && (auto_mode ? tc : step);

  dump_dwell_timer #(.CYCLES(DWELL_CYCLES)) u_tmr (
    .clk  (clk),
    .rst_n(reset),
    .clear(tmr_clr),
    .en   (tmr_en),
    .tc   (tc)
  );

  // The captured word is cleared whenever the address moves so the display
  // never pairs a new address with the previous address's data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      addr_out <= '0;
      cap_word <= '0;
    end else if (start) begin
      state    <= ST_ISSUE;
      addr_out <= '0;
      cap_word <= '0;
    end else begin
      case (state)
        ST_ISSUE:   state <= ST_CAPTURE;
        ST_CAPTURE: begin
          cap_word <= mem_d_in;
          state    <= ST_DWELL;
        end
        ST_DWELL: if (adv) begin
          if (addr_out == LAST) begin
            state <= ST_DONE;
          end else begin
            addr_out <= addr_out + 1'b1;
            cap_word <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_IDLE, ST_DONE: state <= state;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  assign dump_active = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

`ifdef MEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    checksum <= '0;
    else if (start)                checksum <= '0;
    else if (state == ST_CAPTURE)  checksum <= checksum + 16'(mem_d_in);
  end

  assign disp_word = done ? {CHECKSUM_TAG, checksum}
                          : {16'(addr_out), 16'(cap_word)};
`else
  assign disp_word = {16'(addr_out), 16'(cap_word)};
`endif

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed bench for mem_dump_sequencer (LAST_ADDR=3, DWELL_CYCLES=4) with a
// one-cycle-latency RAM model. Table of per-cycle vectors for the auto and
// manual walks, plus hand sequences for restart, start+step, async reset and
// (when MEM_DUMP_CHECKSUM_EN is defined) the checksum.
module tb_mem_dump_sequencer;

  logic        clk, reset, start, step, auto_mode;
  logic [15:0] mem_d_in;
  logic [7:0]  addr_out;
  logic        dump_active, done;
  logic [31:0] disp_word;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [15:0] checksum;
  localparam logic [31:0] DONE_EXP = 32'hC5C5_8006; // A000+A001+A002+A003 mod 2^16
`else
  localparam logic [31:0] DONE_EXP = 32'h0003_A003;
`endif

  logic [15:0] mem [0:255];
  int n_chk = 0, n_fail = 0;

  mem_dump_sequencer #(.ADDR_W(8), .DATA_W(16), .LAST_ADDR(3), .DWELL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .auto_mode(auto_mode),
    .mem_d_in(mem_d_in), .addr_out(addr_out), .dump_active(dump_active),
    .disp_word(disp_word), .done(done)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_d_in <= mem[addr_out];

  typedef struct {
    logic        start, step, auto_m;
    logic [7:0]  addr;
    logic [31:0] disp;
    logic        act, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, logic am, logic [7:0] a,
                              logic [31:0] d, logic ac, logic dn);
    vec_t v;
    v.start = st; v.step = sp; v.auto_m = am; v.addr = a; v.disp = d; v.act = ac; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step_word();
    step = 1; cyc(); step = 0; cyc(); cyc();
  endtask

  initial begin
    logic [15:0] w16;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    reset = 0; start = 0; step = 0; auto_mode = 1;

    // Auto walk: per word ISSUE, CAPTURE, then 4 DWELL cycles.
    for (int w = 0; w < 4; w++) begin
      w16 = 16'(w);
      tbl.push_back(mk(w == 0, 0, 1, 8'(w), {w16, 16'h0000}, 1, 0));
      tbl.push_back(mk(0, 0, 1, 8'(w), {w16, 16'h0000}, 1, 0));
      for (int k = 0; k < 4; k++)
        tbl.push_back(mk(0, 0, 1, 8'(w), {w16, 16'hA000 + w16}, 1, 0));
    end
    tbl.push_back(mk(0, 0, 1, 8'd3, DONE_EXP, 1, 1));
    tbl.push_back(mk(0, 1, 1, 8'd3, DONE_EXP, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'd3, DONE_EXP, 1, 1));
    // Manual walk from DONE: no advance without step.
    tbl.push_back(mk(1, 0, 0, 8'd0, 32'h0000_0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 32'h0000_0000, 1, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 0, 0, 8'd0, 32'h0000_A000, 1, 0));
    for (int w = 1; w < 4; w++) begin
      w16 = 16'(w);
      tbl.push_back(mk(0, 1, 0, 8'(w), {w16, 16'h0000}, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'(w), {w16, 16'h0000}, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'(w), {w16, 16'hA000 + w16}, 1, 0));
    end
    tbl.push_back(mk(0, 1, 0, 8'd3, DONE_EXP, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'd3, DONE_EXP, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'd3, DONE_EXP, 1, 1));

    // Reset state
    #2;
    chk("rst addr", 32'(addr_out), 0);
    chk("rst disp", disp_word, 0);
    chk("rst active", 32'(dump_active), 0);
    chk("rst done", 32'(done), 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("rst checksum", 32'(checksum), 0);
`endif
    @(negedge clk); @(negedge clk); reset = 1;
    cyc();

    // step in IDLE is ignored
    step = 1; cyc(); step = 0; cyc();
    chk("idle step active", 32'(dump_active), 0);
    chk("idle step addr", 32'(addr_out), 0);

    foreach (tbl[i]) begin
      start = tbl[i].start; step = tbl[i].step; auto_mode = tbl[i].auto_m;
      cyc();
      chk($sformatf("tbl[%0d] addr", i), 32'(addr_out), 32'(tbl[i].addr));
      chk($sformatf("tbl[%0d] disp", i), disp_word, tbl[i].disp);
      chk($sformatf("tbl[%0d] active", i), 32'(dump_active), 32'(tbl[i].act));
      chk($sformatf("tbl[%0d] done", i), 32'(done), 32'(tbl[i].dn));
    end
    start = 0; step = 0;

    // Restart during DWELL at addr 2 (auto)
    auto_mode = 1; start = 1; cyc(); start = 0;
    repeat (14) cyc();
    chk("restart setup disp", disp_word, 32'h0002_A002);
    start = 1; cyc(); start = 0;
    chk("restart addr", 32'(addr_out), 0);
    chk("restart disp hi", 32'(disp_word[31:16]), 0);
    chk("restart active", 32'(dump_active), 1);

    // start and step together in manual DWELL at addr 1
    auto_mode = 0; cyc(); cyc();
    step_word();
    chk("ss setup disp", disp_word, 32'h0001_A001);
    start = 1; step = 1; cyc(); start = 0; step = 0;
    chk("ss addr", 32'(addr_out), 0);
    chk("ss disp", disp_word, 32'h0000_0000);

    // Async reset mid-DWELL at addr 2, checked before the next clock edge
    cyc(); cyc();
    step_word(); step_word();
    chk("arst setup addr", 32'(addr_out), 2);
    #3 reset = 0;
    #1;
    chk("arst addr", 32'(addr_out), 0);
    chk("arst disp", disp_word, 0);
    chk("arst active", 32'(dump_active), 0);
    chk("arst done", 32'(done), 0);
    #1 reset = 1;
    cyc();
    chk("arst idle", 32'(dump_active), 0);

`ifdef MEM_DUMP_CHECKSUM_EN
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'hFFFF;
    auto_mode = 1; start = 1; cyc(); start = 0;
    chk("cks cleared", 32'(checksum), 0);
    repeat (24) cyc();
    chk("cks done", 32'(done), 1);
    chk("cks disp", disp_word, 32'hC5C5_0005);
    chk("cks value", 32'(checksum), 32'h0005);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
